// File: rtl/mtm_alu_frame_decoder.sv
// Frame decoder between the ALU deserializer and the ALU core.
// Assembles eight data bytes (B then A, MSB byte first) and a CTL byte into
// either a validated operation or a single-bit error report, and hands the
// result to the core over a valid/ready handshake.
module mtm_alu_frame_decoder #(
    parameter int          N_DATA   = 8,
    parameter logic [3:0]  CRC_POLY = 4'b0011
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        pkt_valid,
    input  logic        pkt_type,
    input  logic [7:0]  pkt_data,
    input  logic        out_ready,
    output logic        out_valid,
    output logic [31:0] A,
    output logic [31:0] B,
    output logic [2:0]  OP,
    output logic        err_valid,
    output logic [2:0]  err_flags,
    output logic        overrun
);

    typedef enum logic {COLLECT, HOLD} state_t;

    localparam logic [3:0] CNT_FULL = 4'(N_DATA);
    localparam logic [3:0] CNT_MAX  = 4'(N_DATA + 1);

    state_t      r_state;
    state_t      w_nextState;
    logic [3:0]  r_byteCnt;
    logic [63:0] r_shift;

    logic        w_isData;
    logic        w_isCmd;
    logic [2:0]  w_ctlOp;
    logic [3:0]  w_ctlCrc;
    logic [3:0]  w_crc;
    logic        w_opOk;
    logic [2:0]  w_flags;
    logic        w_load;
    logic        w_release;
    logic        w_overrun;

    assign w_isData = pkt_valid & ~pkt_type;
    assign w_isCmd  = pkt_valid & pkt_type;
    assign w_ctlOp  = pkt_data[6:4];
    assign w_ctlCrc = pkt_data[3:0];

    // CRC-4 over {B, A, 1'b1, OP}, MSB first, starting from zero
    always_comb begin
        logic [67:0] vec;
        logic        fb;
        vec   = {r_shift, 1'b1, w_ctlOp};
        w_crc = 4'b0000;
        for (int i = 67; i >= 0; i--) begin
            fb    = w_crc[3] ^ vec[i];
            w_crc = {w_crc[2:0], 1'b0} ^ (fb ? CRC_POLY : 4'b0000);
        end
    end

    // Classify the frame closed by the current CTL byte; length beats CRC beats opcode
    always_comb begin
        w_opOk  = (w_ctlOp == 3'b000) || (w_ctlOp == 3'b001) ||
                  (w_ctlOp == 3'b100) || (w_ctlOp == 3'b101);
        w_flags = 3'b000;
        if (r_byteCnt != CNT_FULL) begin
            w_flags = 3'b100;
        end else if (w_crc != w_ctlCrc) begin
            w_flags = 3'b010;
        end else if (!w_opOk) begin
            w_flags = 3'b001;
        end
    end

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= COLLECT;
        end else begin
            r_state <= w_nextState;
        end
    end

    // Next-state logic: load on a command, hand over on ready, drop a command that cannot be held
    always_comb begin
        w_nextState = r_state;
        w_load      = 1'b0;
        w_release   = 1'b0;
        w_overrun   = 1'b0;
        case (r_state)
            COLLECT: begin
                if (w_isCmd) begin
                    w_load      = 1'b1;
                    w_nextState = HOLD;
                end
            end
            HOLD: begin
                if (w_isCmd && out_ready) begin
                    w_load = 1'b1;
                end else if (w_isCmd) begin
                    w_overrun = 1'b1;
                end else if (out_ready) begin
                    w_release   = 1'b1;
                    w_nextState = COLLECT;
                end
            end
            default: w_nextState = COLLECT;
        endcase
    end

    // Byte counter saturates one past a full frame so long frames stay flagged
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_byteCnt <= 4'd0;
        end else if (w_isCmd) begin
            r_byteCnt <= 4'd0;
        end else if (w_isData && (r_byteCnt != CNT_MAX)) begin
            r_byteCnt <= r_byteCnt + 4'd1;
        end
    end

    // Operand shift register keeps the most recent eight data bytes
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_shift <= 64'd0;
        end else if (w_isData) begin
            r_shift <= {r_shift[55:0], pkt_data};
        end
    end

    // Result register: operands only change on a successful frame
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            err_valid <= 1'b0;
            err_flags <= 3'b000;
            A         <= 32'd0;
            B         <= 32'd0;
            OP        <= 3'b000;
            overrun   <= 1'b0;
        end else begin
            overrun <= w_overrun;
            if (w_load) begin
                if (w_flags == 3'b000) begin
                    out_valid <= 1'b1;
                    err_valid <= 1'b0;
                    err_flags <= 3'b000;
                    B         <= r_shift[63:32];
                    A         <= r_shift[31:0];
                    OP        <= w_ctlOp;
                end else begin
                    out_valid <= 1'b0;
                    err_valid <= 1'b1;
                    err_flags <= w_flags;
                end
            end else if (w_release) begin
                out_valid <= 1'b0;
                err_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_mtm_alu_frame_decoder.sv
// Testbench for mtm_alu_frame_decoder: directed frames from the test plan
// followed by random frames, all checked against a frame-level reference model.
module tb_mtm_alu_frame_decoder;

    logic        clk;
    logic        rst_n;
    logic        pkt_valid;
    logic        pkt_type;
    logic [7:0]  pkt_data;
    logic        out_ready;
    logic        out_valid;
    logic [31:0] A;
    logic [31:0] B;
    logic [2:0]  OP;
    logic        err_valid;
    logic [2:0]  err_flags;
    logic        overrun;

    int errCount   = 0;
    int checkCount = 0;

    // Reference model state
    int          mCount;
    logic [63:0] mShift;
    logic        mPending;
    logic        mIsErr;
    logic [2:0]  mFlags;
    logic [31:0] mA;
    logic [31:0] mB;
    logic [2:0]  mOp;
    logic        mOver;

    mtm_alu_frame_decoder dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .pkt_valid (pkt_valid),
        .pkt_type  (pkt_type),
        .pkt_data  (pkt_data),
        .out_ready (out_ready),
        .out_valid (out_valid),
        .A         (A),
        .B         (B),
        .OP        (OP),
        .err_valid (err_valid),
        .err_flags (err_flags),
        .overrun   (overrun)
    );

    // 10 ns clock
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic logic [3:0] crc4(input logic [67:0] v);
        logic [3:0] c;
        logic       fb;
        c = 4'b0000;
        for (int i = 67; i >= 0; i--) begin
            fb = c[3] ^ v[i];
            c  = {c[2:0], 1'b0} ^ (fb ? 4'b0011 : 4'b0000);
        end
        return c;
    endfunction

    function automatic logic [7:0] makeCtl(input logic [31:0] b, input logic [31:0] a,
                                           input logic [2:0] op);
        return {1'b0, op, crc4({b, a, 1'b1, op})};
    endfunction

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checkCount++;
        assert (obs === exp) else begin
            errCount++;
            $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic modelReset();
        mCount   = 0;
        mShift   = 64'd0;
        mPending = 1'b0;
        mIsErr   = 1'b0;
        mFlags   = 3'b000;
        mA       = 32'd0;
        mB       = 32'd0;
        mOp      = 3'b000;
        mOver    = 1'b0;
    endtask

    // Judge the frame closed by command byte 'ctl' from the model's byte history
    task automatic evalFrame(input logic [7:0] ctl);
        logic [2:0] op;
        op = ctl[6:4];
        if (mCount != 8)
            mFlags = 3'b100;
        else if (crc4({mShift, 1'b1, op}) != ctl[3:0])
            mFlags = 3'b010;
        else if (!(op == 3'd0 || op == 3'd1 || op == 3'd4 || op == 3'd5))
            mFlags = 3'b001;
        else
            mFlags = 3'b000;
        mIsErr = (mFlags != 3'b000);
        if (!mIsErr) begin
            mB  = mShift[63:32];
            mA  = mShift[31:0];
            mOp = op;
        end
    endtask

    task automatic checkOutput(input string tag);
        check({tag, ".out_valid"}, 64'(out_valid), 64'(mPending && !mIsErr));
        check({tag, ".err_valid"}, 64'(err_valid), 64'(mPending && mIsErr));
        check({tag, ".overrun"},   64'(overrun),   64'(mOver));
        check({tag, ".A"},         64'(A),         64'(mA));
        check({tag, ".B"},         64'(B),         64'(mB));
        check({tag, ".OP"},        64'(OP),        64'(mOp));
        if (mPending && mIsErr)
            check({tag, ".err_flags"}, 64'(err_flags), 64'(mFlags));
    endtask

    // One clock of stimulus starting at a falling edge; outputs checked at the next falling edge
    task automatic applyStimulus(input logic pv, input logic pt, input logic [7:0] pd,
                                 input logic rdy, input string tag);
        pkt_valid = pv;
        pkt_type  = pt;
        pkt_data  = pd;
        out_ready = rdy;
        mOver = 1'b0;
        if (pv && !pt) begin
            mCount++;
            mShift = {mShift[55:0], pd};
        end else if (pv && pt) begin
            if (!mPending || rdy) begin
                evalFrame(pd);
                mPending = 1'b1;
            end else begin
                mOver = 1'b1;
            end
            mCount = 0;
        end
        if (!(pv && pt) && mPending && rdy)
            mPending = 1'b0;
        @(negedge clk);
        pkt_valid = 1'b0;
        checkOutput(tag);
    endtask

    task automatic sendFrame(input logic [31:0] b, input logic [31:0] a, input int nBytes,
                             input logic [7:0] ctl, input logic rdy, input string tag);
        logic [63:0] bytesVec;
        bytesVec = {b, a};
        for (int i = 0; i < nBytes; i++) begin
            if (i < 8)
                applyStimulus(1'b1, 1'b0, bytesVec[63 - 8*i -: 8], 1'b0, tag);
            else
                applyStimulus(1'b1, 1'b0, 8'h00, 1'b0, tag);
        end
        applyStimulus(1'b1, 1'b1, ctl, rdy, tag);
    endtask

    task automatic doReset(input string tag);
        rst_n     = 1'b0;
        pkt_valid = 1'b0;
        out_ready = 1'b0;
        modelReset();
        #2;
        checkOutput(tag);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        logic [31:0] rb;
        logic [31:0] ra;
        logic [2:0]  rop;
        logic [7:0]  rctl;
        int          nb;

        rst_n     = 1'b0;
        pkt_valid = 1'b0;
        pkt_type  = 1'b0;
        pkt_data  = 8'h00;
        out_ready = 1'b0;
        modelReset();
        @(negedge clk);
        @(negedge clk);
        checkOutput("reset");
        rst_n = 1'b1;

        // ADD on zero operands, then handoff
        sendFrame(32'd0, 32'd0, 8, 8'h47, 1'b0, "add0");
        check("add0.op100", 64'(OP), 64'(3'b100));
        applyStimulus(1'b0, 1'b0, 8'h00, 1'b1, "add0.ready");
        check("add0.dropped", 64'(out_valid), 64'd0);

        // AND with correct and wrong CRC
        sendFrame(32'd0, 32'd0, 8, 8'h0B, 1'b0, "and.ok");
        applyStimulus(1'b0, 1'b0, 8'h00, 1'b1, "and.ok.ready");
        sendFrame(32'd0, 32'd0, 8, 8'h0A, 1'b0, "and.crc");
        check("and.crc.flags", 64'(err_flags), 64'(3'b010));
        applyStimulus(1'b0, 1'b0, 8'h00, 1'b1, "and.crc.ready");

        // Unsupported opcode with correct CRC
        sendFrame(32'd0, 32'd0, 8, 8'h2D, 1'b0, "badop");
        check("badop.flags", 64'(err_flags), 64'(3'b001));
        applyStimulus(1'b0, 1'b0, 8'h00, 1'b1, "badop.ready");

        // Short and long frames
        sendFrame(32'd0, 32'd0, 7, 8'h47, 1'b0, "short");
        check("short.flags", 64'(err_flags), 64'(3'b100));
        applyStimulus(1'b0, 1'b0, 8'h00, 1'b1, "short.ready");
        sendFrame(32'd0, 32'd0, 9, 8'h47, 1'b0, "long");
        check("long.flags", 64'(err_flags), 64'(3'b100));
        applyStimulus(1'b0, 1'b0, 8'h00, 1'b1, "long.ready");

        // Overrun while holding, then back-to-back handoff
        sendFrame(32'h11223344, 32'h55667788, 8, makeCtl(32'h11223344, 32'h55667788, 3'b101),
                  1'b0, "ovr.f1");
        sendFrame(32'hA5A5A5A5, 32'h0000FFFF, 8, makeCtl(32'hA5A5A5A5, 32'h0000FFFF, 3'b001),
                  1'b0, "ovr.f2");
        check("ovr.pulse", 64'(overrun), 64'd1);
        check("ovr.keepA", 64'(A), 64'(32'h55667788));
        applyStimulus(1'b0, 1'b0, 8'h00, 1'b0, "ovr.idle");
        sendFrame(32'hA5A5A5A5, 32'h0000FFFF, 8, makeCtl(32'hA5A5A5A5, 32'h0000FFFF, 3'b001),
                  1'b1, "b2b");
        check("b2b.valid", 64'(out_valid), 64'd1);
        check("b2b.B", 64'(B), 64'(32'hA5A5A5A5));
        applyStimulus(1'b0, 1'b0, 8'h00, 1'b1, "b2b.ready");

        // Reset in the middle of a frame
        for (int i = 0; i < 4; i++)
            applyStimulus(1'b1, 1'b0, 8'hFF, 1'b0, "mid");
        doReset("midreset");
        sendFrame(32'd0, 32'd0, 8, 8'h47, 1'b0, "postreset");
        check("postreset.valid", 64'(out_valid), 64'd1);
        applyStimulus(1'b0, 1'b0, 8'h00, 1'b1, "postreset.ready");

        // Random frames: mostly well formed, random handshake timing
        for (int f = 0; f < 150; f++) begin
            rb  = $urandom;
            ra  = $urandom;
            rop = 3'($urandom_range(0, 7));
            case ($urandom_range(0, 9))
                0:       nb = 7;
                1:       nb = 9;
                default: nb = 8;
            endcase
            rctl = makeCtl(rb, ra, rop);
            if ($urandom_range(0, 5) == 0)
                rctl[3:0] = rctl[3:0] ^ 4'(($urandom_range(1, 15)));
            if ($urandom_range(0, 3) == 0)
                rctl[7] = 1'b1;
            for (int i = 0; i < nb; i++)
                applyStimulus(1'b1, 1'b0, (i < 8) ? 8'(({rb, ra} >> (56 - 8*i))) : 8'($urandom),
                              1'($urandom_range(0, 1)), "rand.data");
            applyStimulus(1'b1, 1'b1, rctl, 1'($urandom_range(0, 2) != 0), "rand.cmd");
            for (int k = 0; k < int'($urandom_range(0, 2)); k++)
                applyStimulus(1'b0, 1'b0, 8'h00, 1'($urandom_range(0, 1)), "rand.idle");
        end

        $display("Result: errors=%0d of %0d checks", errCount, checkCount);
        $finish;
    end

endmodule
